// File: rtl/k423_pkg.sv
// Shared widths, WB beat and commit-trace types for the k423 writeback slice.
// Trace record contents are used when K423_WB_TRACE_EN is defined.
package k423_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int RIDX_W = 5;
    localparam int CNT_W  = 64;
    localparam int NREG   = 1 << RIDX_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              rd_vld;
        logic [RIDX_W-1:0] rd_idx;
        logic [XLEN-1:0]   rd;
    } wb_beat_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] pc;
        logic [RIDX_W-1:0] rd_idx;
        logic [XLEN-1:0]   rd;
    } trace_t;

    function automatic logic byp_hit(
        input logic              we,
        input logic [RIDX_W-1:0] widx,
        input logic [RIDX_W-1:0] ridx
    );
        return we && (widx != '0) && (widx == ridx);
    endfunction

endpackage

// File: rtl/k423_regfile_2r1w.sv
// Integer register file: 2 combinational read ports, 1 write port,
// x0 hardwired to zero, write-through bypass on the read ports.
module k423_regfile_2r1w
    import k423_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [RIDX_W-1:0] rs1_idx,
    output logic [XLEN-1:0]   rs1,
    input  logic [RIDX_W-1:0] rs2_idx,
    output logic [XLEN-1:0]   rs2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // A same-cycle write to the index being read returns the new data.
    always_comb begin
        rs1 = '0;
        if (byp_hit(we, wr_idx, rs1_idx)) begin
            rs1 = wr_data;
        end else if (rs1_idx != '0) begin
            rs1 = regs[rs1_idx];
        end
    end

    always_comb begin
        rs2 = '0;
        if (byp_hit(we, wr_idx, rs2_idx)) begin
            rs2 = wr_data;
        end else if (rs2_idx != '0) begin
            rs2 = regs[rs2_idx];
        end
    end

endmodule

// File: rtl/k423_wb_regfile.sv
// Writeback stage: commits WB beats and debug writes, retire counter, trace.
// Define K423_WB_TRACE_EN to build the registered commit-trace port.
module k423_wb_regfile
    import k423_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem2wb_stage_vld_i,
    output logic              wb_stage_rdy_o,
    input  logic [ADDR_W-1:0] wb_pc_i,
    input  logic              wb_rd_vld_i,
    input  logic [RIDX_W-1:0] wb_rd_idx_i,
    input  logic [XLEN-1:0]   wb_rd_i,
    input  logic [RIDX_W-1:0] id_rs1_idx_i,
    output logic [XLEN-1:0]   id_rs1_o,
    input  logic [RIDX_W-1:0] id_rs2_idx_i,
    output logic [XLEN-1:0]   id_rs2_o,
    input  logic              dbg_wr_req_i,
    input  logic [RIDX_W-1:0] dbg_wr_idx_i,
    input  logic [XLEN-1:0]   dbg_wr_data_i,
    output logic              dbg_wr_ack_o,
    output logic [CNT_W-1:0]  retire_cnt_o,
    output logic              trace_vld_o,
    output logic [ADDR_W-1:0] trace_pc_o,
    output logic [RIDX_W-1:0] trace_rd_idx_o,
    output logic [XLEN-1:0]   trace_rd_o
);

    wb_beat_t          beat;
    logic              accept;
    logic              wb_wr;
    logic              dbg_wr;
    logic              rf_we;
    logic [RIDX_W-1:0] rf_idx;
    logic [XLEN-1:0]   rf_data;
    logic [CNT_W-1:0]  retire_cnt_q;
    logic              dbg_ack_q;

    assign beat = '{pc: wb_pc_i, rd_vld: wb_rd_vld_i,
                    rd_idx: wb_rd_idx_i, rd: wb_rd_i};

    // Debug owns the single write port, so WB is held off while it asks.
    assign wb_stage_rdy_o = ~rst_i & ~dbg_wr_req_i;
    assign accept         = mem2wb_stage_vld_i & wb_stage_rdy_o;
    assign wb_wr          = accept & beat.rd_vld & (beat.rd_idx != '0);
    assign dbg_wr         = dbg_wr_req_i & ~rst_i;

    always_comb begin
        rf_we   = 1'b0;
        rf_idx  = beat.rd_idx;
        rf_data = beat.rd;
        unique case (1'b1)
            dbg_wr: begin
                rf_we   = 1'b1;
                rf_idx  = dbg_wr_idx_i;
                rf_data = dbg_wr_data_i;
            end
            wb_wr: begin
                rf_we = 1'b1;
            end
            default: ;
        endcase
    end

    k423_regfile_2r1w u_rf (
        .clk     (clk_i),
        .rst     (rst_i),
        .we      (rf_we),
        .wr_idx  (rf_idx),
        .wr_data (rf_data),
        .rs1_idx (id_rs1_idx_i),
        .rs1     (id_rs1_o),
        .rs2_idx (id_rs2_idx_i),
        .rs2     (id_rs2_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt_q <= '0;
            dbg_ack_q    <= 1'b0;
        end else begin
            dbg_ack_q <= dbg_wr_req_i;
            if (accept) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign retire_cnt_o = retire_cnt_q;
    assign dbg_wr_ack_o = dbg_ack_q;

`ifdef K423_WB_TRACE_EN
    trace_t trace_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trace_q <= '0;
        end else begin
            trace_q.vld <= accept;
            if (accept) begin
                trace_q.pc     <= beat.pc;
                trace_q.rd_idx <= wb_wr ? beat.rd_idx : '0;
                trace_q.rd     <= wb_wr ? beat.rd : '0;
            end
        end
    end

    assign trace_vld_o    = trace_q.vld;
    assign trace_pc_o     = trace_q.pc;
    assign trace_rd_idx_o = trace_q.rd_idx;
    assign trace_rd_o     = trace_q.rd;
`else
    logic unused_pc;
    assign unused_pc = ^beat.pc;

    assign trace_vld_o    = 1'b0;
    assign trace_pc_o     = '0;
    assign trace_rd_idx_o = '0;
    assign trace_rd_o     = '0;
`endif

endmodule

// File: tb/tb_k423_wb_regfile.sv
// Self-checking bench for k423_wb_regfile; trace checks follow K423_WB_TRACE_EN.
module tb_k423_wb_regfile;
    import k423_pkg::*;

`ifdef K423_WB_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vld = 1'b0;
    logic              rdy;
    logic [ADDR_W-1:0] pc = '0;
    logic              rd_vld = 1'b0;
    logic [RIDX_W-1:0] rd_idx = '0;
    logic [XLEN-1:0]   rd = '0;
    logic [RIDX_W-1:0] rs1_idx = '0;
    logic [XLEN-1:0]   rs1;
    logic [RIDX_W-1:0] rs2_idx = '0;
    logic [XLEN-1:0]   rs2;
    logic              dbg_req = 1'b0;
    logic [RIDX_W-1:0] dbg_idx = '0;
    logic [XLEN-1:0]   dbg_data = '0;
    logic              dbg_ack;
    logic [CNT_W-1:0]  cnt;
    logic              tr_vld;
    logic [ADDR_W-1:0] tr_pc;
    logic [RIDX_W-1:0] tr_idx;
    logic [XLEN-1:0]   tr_rd;

    k423_wb_regfile dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem2wb_stage_vld_i (vld),
        .wb_stage_rdy_o     (rdy),
        .wb_pc_i            (pc),
        .wb_rd_vld_i        (rd_vld),
        .wb_rd_idx_i        (rd_idx),
        .wb_rd_i            (rd),
        .id_rs1_idx_i       (rs1_idx),
        .id_rs1_o           (rs1),
        .id_rs2_idx_i       (rs2_idx),
        .id_rs2_o           (rs2),
        .dbg_wr_req_i       (dbg_req),
        .dbg_wr_idx_i       (dbg_idx),
        .dbg_wr_data_i      (dbg_data),
        .dbg_wr_ack_o       (dbg_ack),
        .retire_cnt_o       (cnt),
        .trace_vld_o        (tr_vld),
        .trace_pc_o         (tr_pc),
        .trace_rd_idx_o     (tr_idx),
        .trace_rd_o         (tr_rd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    trace_t trq[$];
    logic [XLEN-1:0] rdq[$];
    logic [XLEN-1:0] model [NREG];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int port,
                          input logic [RIDX_W-1:0] idx,
                          input logic [XLEN-1:0] exp);
        logic [XLEN-1:0] got;
        if (port == 1) rs1_idx = idx;
        else rs2_idx = idx;
        rdq.push_back(exp);
        #1;
        got = (port == 1) ? rs1 : rs2;
        check(tag, {32'h0, got}, {32'h0, rdq.pop_front()});
    endtask

    // Drive a beat; expected commit goes to the model and trace queue.
    task automatic beat(input logic [ADDR_W-1:0] p, input logic rv,
                        input logic [RIDX_W-1:0] idx,
                        input logic [XLEN-1:0] d);
        trace_t t;
        vld = 1'b1; pc = p; rd_vld = rv; rd_idx = idx; rd = d;
        t.vld    = 1'b1;
        t.pc     = p;
        t.rd_idx = (rv && idx != '0) ? idx : '0;
        t.rd     = (rv && idx != '0) ? d : '0;
        if (TRACE) trq.push_back(t);
        if (rv && idx != '0) model[idx] = d;
    endtask

    task automatic idle();
        vld = 1'b0; rd_vld = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 1; i < NREG; i++) begin
            @(negedge clk);
            rd_chk(tag, 1 + (i % 2), RIDX_W'(i), model[i]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && tr_vld) begin
            if (trq.size() == 0) begin
                check("trace_spurious", 64'(tr_vld), 64'h0);
            end else begin
                trace_t t;
                t = trq.pop_front();
                check("trace_pc", 64'(tr_pc), 64'(t.pc));
                check("trace_idx", 64'(tr_idx), 64'(t.rd_idx));
                check("trace_rd", 64'(tr_rd), 64'(t.rd));
            end
        end
    end

    initial begin
        for (int i = 0; i < NREG; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_trace_vld", 64'(tr_vld), 64'h0);
        rst = 1'b0;

        // Reset state
        sweep("rst_reg");
        @(negedge clk);
        check("rst_cnt", cnt, 64'h0);
        check("rst_rdy", 64'(rdy), 64'h1);
        check("rst_ack", 64'(dbg_ack), 64'h0);

        // Commit with same-cycle bypass
        @(negedge clk);
        beat(32'h100, 1'b1, 5'd5, 32'hDEADBEEF);
        rd_chk("byp_x5", 1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        idle();
        rd_chk("held_x5", 1, 5'd5, 32'hDEADBEEF);
        check("cnt_1", cnt, 64'd1);

        // x0 write dropped, still retires
        beat(32'h104, 1'b1, 5'd0, 32'h1234);
        rd_chk("x0_byp", 2, 5'd0, 32'h0);
        @(negedge clk);
        idle();
        rd_chk("x0_read", 2, 5'd0, 32'h0);
        check("cnt_2", cnt, 64'd2);

        // Debug write stalls a pending WB beat
        dbg_req = 1'b1; dbg_idx = 5'd7; dbg_data = 32'h55;
        model[7] = 32'h55;
        vld = 1'b1; pc = 32'h108; rd_vld = 1'b1;
        rd_idx = 5'd9; rd = 32'hA5A5;
        #1 check("dbg_rdy", 64'(rdy), 64'h0);
        rd_chk("dbg_byp", 1, 5'd7, 32'h55);
        rd_chk("stall_nobyp", 2, 5'd9, 32'h0);
        @(negedge clk);
        check("dbg_ack", 64'(dbg_ack), 64'h1);
        check("stall_cnt", cnt, 64'd2);
        dbg_req = 1'b0;
        beat(32'h108, 1'b1, 5'd9, 32'hA5A5);
        #1 check("rel_rdy", 64'(rdy), 64'h1);
        rd_chk("rel_byp", 2, 5'd9, 32'hA5A5);
        @(negedge clk);
        idle();
        check("ack_drop", 64'(dbg_ack), 64'h0);
        check("cnt_3", cnt, 64'd3);
        rd_chk("dbg_x7", 1, 5'd7, 32'h55);
        rd_chk("wb_x9", 2, 5'd9, 32'hA5A5);

        // Back-to-back beats
        for (int i = 0; i < 3; i++) begin
            beat(32'h200 + 32'(4 * i), 1'b1, RIDX_W'(10 + i),
                 32'hC0DE0000 + 32'(i));
            @(negedge clk);
        end
        idle();
        check("cnt_6", cnt, 64'd6);
        sweep("model");

        // Counter wrap
        @(negedge clk);
        force dut.retire_cnt_q = '1;
        #1 release dut.retire_cnt_q;
        check("cnt_forced", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(32'h300, 1'b0, 5'd3, 32'h77);
        @(negedge clk);
        idle();
        check("cnt_wrap", cnt, 64'h0);
        @(negedge clk);
        @(negedge clk);
        check("trace_pending", 64'(trq.size()), 64'h0);

        // Reset mid-operation discards beat and debug write
        beat(32'h400, 1'b1, 5'd13, 32'hBAD0);
        dbg_req = 1'b1; dbg_idx = 5'd14; dbg_data = 32'hBAD1;
        if (TRACE) void'(trq.pop_back());
        #2 rst = 1'b1;
        @(negedge clk);
        idle();
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        check("mid_cnt", cnt, 64'h0);
        check("mid_ack", 64'(dbg_ack), 64'h0);
        check("mid_trace", 64'(tr_vld), 64'h0);
        sweep("mid_reg");
        @(negedge clk);
        check("trace_left", 64'(trq.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
